// File: rtl/ppu_pkg.sv
// Shared constants and loopy-register helpers for the PPU VRAM address unit.
// Loopy v/t layout: [14:12] fine Y, [11] NT Y, [10] NT X, [9:5] coarse Y, [4:0] coarse X.
package ppu_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_SCROLL = 3'd5;
  localparam logic [2:0] REG_ADDR   = 3'd6;

  localparam logic [13:0] NT_BASE = 14'h2000;
  localparam logic [13:0] AT_BASE = 14'h23C0;

  localparam int CX_LSB  = 0;
  localparam int CY_LSB  = 5;
  localparam int NTX_BIT = 10;
  localparam int NTY_BIT = 11;
  localparam int FY_LSB  = 12;

  // Fields restored by the horizontal copy and by return00 respectively.
  localparam logic [14:0] HORIZ_MASK = 15'h041F;
  localparam logic [14:0] VERT_MASK  = 15'h7BE0;

  function automatic logic [14:0] inc_coarse_x(input logic [14:0] v);
    logic [14:0] r;
    r = v;
    if (r[CX_LSB +: 5] == 5'd31) begin
      r[CX_LSB +: 5] = 5'd0;
      r[NTX_BIT]     = ~r[NTX_BIT];
    end else begin
      r[CX_LSB +: 5] = r[CX_LSB +: 5] + 5'd1;
    end
    return r;
  endfunction

  // Row 29 is the last visible tile row; 30/31 address attribute space and wrap silently.
  function automatic logic [14:0] inc_y_fn(input logic [14:0] v);
    logic [14:0] r;
    r = v;
    if (r[FY_LSB +: 3] != 3'd7) begin
      r[FY_LSB +: 3] = r[FY_LSB +: 3] + 3'd1;
    end else begin
      r[FY_LSB +: 3] = 3'd0;
      if (r[CY_LSB +: 5] == 5'd29) begin
        r[CY_LSB +: 5] = 5'd0;
        r[NTY_BIT]     = ~r[NTY_BIT];
      end else if (r[CY_LSB +: 5] == 5'd31) begin
        r[CY_LSB +: 5] = 5'd0;
      end else begin
        r[CY_LSB +: 5] = r[CY_LSB +: 5] + 5'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vaddr_inc.sv
// Combinational next-v candidates: scroll increments and the $2007 access step.
module vaddr_inc
  import ppu_pkg::*;
(
  input  logic [14:0] v,
  input  logic        do_cx,
  input  logic        do_y,
  input  logic        inc32,
  output logic [14:0] v_scroll,
  output logic [14:0] v_acc
);

  always_comb begin
    v_scroll = v;
    if (do_cx) v_scroll = inc_coarse_x(v_scroll);
    if (do_y)  v_scroll = inc_y_fn(v_scroll);
  end

  assign v_acc = v + (inc32 ? 15'd32 : 15'd1);

endmodule

// File: rtl/vram_fetch.sv
// PPU VRAM address unit: loopy v/t/fine-X/w registers and renderer fetch responder.
// Build option: VRAM_FETCH_2007_GLITCH_EN makes $2007 access during rendering bump coarse X and Y.
module vram_fetch
  import ppu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wr,
  input  logic [2:0]  reg_sel,
  input  logic [7:0]  reg_din,
  input  logic        status_rd,
  input  logic        data_acc,
  input  logic [7:0]  ppuctrl,
  input  logic        rend,
  input  logic        fetch_attr,
  input  logic        fetch_chr,
  input  logic [12:0] pattern_idx,
  input  logic        inc_cx,
  input  logic        inc_y,
  input  logic        return00,
  output logic [13:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_din,
  output logic [7:0]  data_o,
  output logic [1:0]  attr_o,
  output logic [2:0]  fine_x,
  output logic [14:0] v_o
);

  logic [14:0] v, t, t_nxt, v_nxt, v_scroll, v_acc;
  logic [2:0]  fx_nxt;
  logic [1:0]  q;
  logic        w, w_nxt, load_v, hcopy_pend, do_cx, do_y;
  logic        unused_ctrl;

  assign unused_ctrl = ^{ppuctrl[7:3], ppuctrl[1:0]};

`ifdef VRAM_FETCH_2007_GLITCH_EN
  assign do_cx = inc_cx | (data_acc & rend);
  assign do_y  = inc_y  | (data_acc & rend);
`else
  assign do_cx = inc_cx;
  assign do_y  = inc_y;
`endif

  vaddr_inc u_inc (
    .v        (v),
    .do_cx    (do_cx),
    .do_y     (do_y),
    .inc32    (ppuctrl[2]),
    .v_scroll (v_scroll),
    .v_acc    (v_acc)
  );

  // CPU register side; a coincident $2002 read lets the write see the old w, then clears it.
  always_comb begin
    t_nxt  = t;
    w_nxt  = w;
    fx_nxt = fine_x;
    load_v = 1'b0;
    if (reg_wr) begin
      unique case (reg_sel)
        REG_CTRL: t_nxt[NTX_BIT +: 2] = reg_din[1:0];
        REG_SCROLL: begin
          if (!w) begin
            t_nxt[CX_LSB +: 5] = reg_din[7:3];
            fx_nxt             = reg_din[2:0];
            w_nxt              = 1'b1;
          end else begin
            t_nxt[FY_LSB +: 3] = reg_din[2:0];
            t_nxt[CY_LSB +: 5] = reg_din[7:3];
            w_nxt              = 1'b0;
          end
        end
        REG_ADDR: begin
          if (!w) begin
            t_nxt[13:8] = reg_din[5:0];
            t_nxt[14]   = 1'b0;
            w_nxt       = 1'b1;
          end else begin
            t_nxt[7:0] = reg_din;
            load_v     = 1'b1;
            w_nxt      = 1'b0;
          end
        end
        default: ;
      endcase
    end
    if (status_rd) w_nxt = 1'b0;
  end

  always_comb begin
    v_nxt = v;
    if (load_v) begin
      v_nxt = t_nxt;
    end else if (return00 || (hcopy_pend && rend)) begin
      if (return00)             v_nxt = (v_nxt & ~VERT_MASK)  | (t & VERT_MASK);
      if (hcopy_pend && rend)   v_nxt = (v_nxt & ~HORIZ_MASK) | (t & HORIZ_MASK);
    end else if (do_cx || do_y) begin
      v_nxt = v_scroll;
    end else if (data_acc && !rend) begin
      v_nxt = v_acc;
    end
  end

  // Requests and address are same-cycle (N); vram_din answers in N+1 and is passed straight through.
  always_comb begin
    vram_addr = v[13:0];
    if (rend) begin
      if (fetch_chr)       vram_addr = {1'b0, pattern_idx};
      else if (fetch_attr) vram_addr = AT_BASE | {2'b00, v[11:10], 4'b0000, v[9:7], v[4:2]};
      else                 vram_addr = NT_BASE | {2'b00, v[11:0]};
    end
  end

  always_comb begin
    unique case (q)
      2'd0:    attr_o = vram_din[1:0];
      2'd1:    attr_o = vram_din[3:2];
      2'd2:    attr_o = vram_din[5:4];
      default: attr_o = vram_din[7:6];
    endcase
  end

  assign vram_rd = rend;
  assign data_o  = vram_din;
  assign v_o     = v;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v          <= '0;
      t          <= '0;
      fine_x     <= '0;
      w          <= 1'b0;
      q          <= '0;
      hcopy_pend <= 1'b0;
    end else begin
      v          <= v_nxt;
      t          <= t_nxt;
      fine_x     <= fx_nxt;
      w          <= w_nxt;
      hcopy_pend <= inc_y;
      if (fetch_attr) q <= {v[6], v[1]};
    end
  end

endmodule

// File: tb/tb_vram_fetch.sv
// Self-checking bench for vram_fetch: directed scroll/address scenarios plus randomized
// traffic checked against a field-level model of the loopy registers and a VRAM image.
module tb_vram_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_wr, status_rd, data_acc, rend, fetch_attr, fetch_chr;
  logic        inc_cx, inc_y, return00;
  logic [2:0]  reg_sel;
  logic [7:0]  reg_din, ppuctrl, vram_din;
  logic [12:0] pattern_idx;
  logic [13:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  data_o;
  logic [1:0]  attr_o;
  logic [2:0]  fine_x;
  logic [14:0] v_o;

`ifdef VRAM_FETCH_2007_GLITCH_EN
  localparam bit GLITCH = 1'b1;
`else
  localparam bit GLITCH = 1'b0;
`endif

  vram_fetch dut (
    .clk(clk), .rst(rst), .reg_wr(reg_wr), .reg_sel(reg_sel), .reg_din(reg_din),
    .status_rd(status_rd), .data_acc(data_acc), .ppuctrl(ppuctrl), .rend(rend),
    .fetch_attr(fetch_attr), .fetch_chr(fetch_chr), .pattern_idx(pattern_idx),
    .inc_cx(inc_cx), .inc_y(inc_y), .return00(return00), .vram_addr(vram_addr),
    .vram_rd(vram_rd), .vram_din(vram_din), .data_o(data_o), .attr_o(attr_o),
    .fine_x(fine_x), .v_o(v_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] mem [0:16383];
  int mv, mt, mw, mfx, mq, mhc;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int pack(int fy, int nty, int ntx, int cy, int cx);
    return fy * 4096 + nty * 2048 + ntx * 1024 + cy * 32 + cx;
  endfunction

  function automatic int exp_addr();
    int cx, cy, ntx, nty;
    cx = mv % 32; cy = (mv / 32) % 32; ntx = (mv / 1024) % 2; nty = (mv / 2048) % 2;
    if (rend) begin
      if (fetch_chr)  return int'(pattern_idx);
      if (fetch_attr) return 'h23C0 + nty * 2048 + ntx * 1024 + (cy / 4) * 8 + cx / 4;
      return 'h2000 + mv % 4096;
    end
    return mv % 16384;
  endfunction

  task automatic model_reset();
    mv = 0; mt = 0; mw = 0; mfx = 0; mq = 0; mhc = 0;
    exp_q.delete();
  endtask

  task automatic model_update();
    int nv, nt, nw, nfx, d;
    int fy, nty, ntx, cy, cx, tfy, tnty, tntx, tcy, tcx;
    bit load, g;
    nv = mv; nt = mt; nw = mw; nfx = mfx; load = 1'b0; d = int'(reg_din);
    fy  = mv / 4096; nty  = (mv / 2048) % 2; ntx  = (mv / 1024) % 2; cy  = (mv / 32) % 32; cx  = mv % 32;
    tfy = mt / 4096; tnty = (mt / 2048) % 2; tntx = (mt / 1024) % 2; tcy = (mt / 32) % 32; tcx = mt % 32;
    if (reg_wr) begin
      if (reg_sel == 3'd0) nt = pack(tfy, d / 2 % 2, d % 2, tcy, tcx);
      else if (reg_sel == 3'd5) begin
        if (mw == 0) begin nt = pack(tfy, tnty, tntx, tcy, d / 8); nfx = d % 8; nw = 1; end
        else begin nt = pack(d % 8, tnty, tntx, d / 8, tcx); nw = 0; end
      end else if (reg_sel == 3'd6) begin
        if (mw == 0) begin nt = (d % 64) * 256 + mt % 256; nw = 1; end
        else begin nt = (mt / 256) * 256 + d; load = 1'b1; nw = 0; end
      end
    end
    if (status_rd) nw = 0;
    if (fetch_attr) mq = ((cy / 2) % 2) * 2 + (cx / 2) % 2;
    g = GLITCH && data_acc && rend;
    if (load) nv = nt;
    else if (return00 || (mhc != 0 && rend)) begin
      if (return00) begin fy = tfy; nty = tnty; cy = tcy; end
      if (mhc != 0 && rend) begin ntx = tntx; cx = tcx; end
      nv = pack(fy, nty, ntx, cy, cx);
    end else if (inc_cx || inc_y || g) begin
      if (inc_cx || g) begin
        if (cx == 31) begin cx = 0; ntx = 1 - ntx; end else cx++;
      end
      if (inc_y || g) begin
        if (fy < 7) fy++;
        else begin
          fy = 0;
          if (cy == 29) begin cy = 0; nty = 1 - nty; end
          else if (cy == 31) cy = 0;
          else cy++;
        end
      end
      nv = pack(fy, nty, ntx, cy, cx);
    end else if (data_acc && !rend) nv = (mv + (ppuctrl[2] ? 32 : 1)) % 32768;
    mhc = int'(inc_y); mv = nv; mt = nt; mw = nw; mfx = nfx;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    reg_wr = 1'b0; reg_sel = 3'd0; reg_din = 8'h00; status_rd = 1'b0; data_acc = 1'b0;
    ppuctrl = 8'h00; rend = 1'b0; fetch_attr = 1'b0; fetch_chr = 1'b0; pattern_idx = '0;
    inc_cx = 1'b0; inc_y = 1'b0; return00 = 1'b0;
  endtask

  task automatic apply_and_check();
    int a;
    logic [7:0] din;
    if (exp_q.size() > 0) din = exp_q.pop_front();
    else din = 8'($urandom);
    vram_din = din;
    #1;
    a = exp_addr();
    check("vram_addr", 32'(vram_addr), 32'(a));
    check("vram_rd", 32'(vram_rd), 32'(rend));
    check("data_o", 32'(data_o), 32'(din));
    check("attr_o", 32'(attr_o), 32'((din >> (2 * mq)) & 8'h03));
    check("v_o", 32'(v_o), 32'(mv));
    check("fine_x", 32'(fine_x), 32'(mfx));
    exp_q.push_back(mem[a[13:0]]);
  endtask

  task automatic advance();
    model_update();
    @(negedge clk);
  endtask

  task automatic cyc();
    apply_and_check();
    advance();
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] d);
    idle();
    reg_wr = 1'b1; reg_sel = sel; reg_din = d;
    cyc();
    idle();
  endtask

  task automatic pulse_reset();
    idle();
    rst = 1'b0;
    vram_din = 8'hA6;
    #1;
    model_reset();
    check("rst_v", 32'(v_o), 32'h0);
    check("rst_fine_x", 32'(fine_x), 32'h0);
    check("rst_addr", 32'(vram_addr), 32'h0);
    check("rst_rd", 32'(vram_rd), 32'h0);
    check("rst_attr", 32'(attr_o), 32'h2);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] sel_tab [4];
    sel_tab[0] = 3'd0; sel_tab[1] = 3'd5; sel_tab[2] = 3'd6; sel_tab[3] = 3'd2;
    rst = 1'b0;
    vram_din = 8'h00;
    idle();
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    model_reset();
    @(negedge clk);
    pulse_reset();

    // scroll writes, then expose t through Y increment + horizontal copy + return00
    wr(3'd5, 8'h7D);
    check("plan_fine_x", 32'(fine_x), 32'h5);
    wr(3'd5, 8'h5E);
    inc_y = 1'b1; cyc(); idle();
    rend = 1'b1;  cyc(); idle();
    return00 = 1'b1; cyc(); idle();
    check("plan_t_scroll", 32'(v_o), 32'h616F);

    wr(3'd6, 8'h23); wr(3'd6, 8'hDF);
    check("plan_2006", 32'(v_o), 32'h23DF);
    data_acc = 1'b1; ppuctrl = 8'h04; cyc(); idle();
    check("plan_acc32", 32'(v_o), 32'h23FF);

    wr(3'd6, 8'h00); wr(3'd6, 8'h1F);
    inc_cx = 1'b1; cyc(); idle();
    check("plan_inc_cx", 32'(v_o), 32'h0400);

    wr(3'd6, 8'h00); wr(3'd6, 8'h00); wr(3'd5, 8'h00); wr(3'd5, 8'hEF);
    return00 = 1'b1; cyc(); idle();
    check("plan_ret00", 32'(v_o), 32'h73A0);
    inc_y = 1'b1; cyc(); idle();
    check("plan_inc_y", 32'(v_o), 32'h0800);

    wr(3'd6, 8'h0C); wr(3'd6, 8'h4E);
    mem[14'h2FC3] = 8'hC0;
    rend = 1'b1; fetch_attr = 1'b1;
    apply_and_check();
    check("plan_attr_addr", 32'(vram_addr), 32'h2FC3);
    advance(); idle();
    apply_and_check();
    check("plan_attr_o", 32'(attr_o), 32'h3);
    advance();

    wr(3'd6, 8'h00); wr(3'd6, 8'h1F);
    rend = 1'b1; data_acc = 1'b1; cyc(); idle();
    check("plan_glitch", 32'(v_o), GLITCH ? 32'h1400 : 32'h001F);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) pulse_reset();
      reg_wr      = ($urandom_range(0, 7) == 0);
      reg_sel     = sel_tab[$urandom_range(0, 3)];
      reg_din     = 8'($urandom);
      status_rd   = ($urandom_range(0, 19) == 0);
      data_acc    = ($urandom_range(0, 7) == 0);
      ppuctrl     = 8'($urandom);
      rend        = ($urandom_range(0, 3) != 0);
      fetch_attr  = ($urandom_range(0, 3) == 0);
      fetch_chr   = ($urandom_range(0, 3) == 0);
      pattern_idx = 13'($urandom);
      inc_cx      = ($urandom_range(0, 3) == 0);
      inc_y       = ($urandom_range(0, 7) == 0);
      return00    = ($urandom_range(0, 15) == 0);
      cyc();
    end
    idle();

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
